// File: rtl/run_ctrl_pkg.sv
// Shared types and widths for the run_ctrl CPU run sequencer.
package run_ctrl_pkg;

   localparam int STATE_W = 3;
   localparam int CNT_W   = 32;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      CRST  = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      STEP  = 3'd4,
      DONE  = 3'd5
   } state_t;

   function automatic logic cpu_on(input state_t s);
      return (s == RUN) || (s == STEP);
   endfunction

endpackage

// File: rtl/run_ctrl_cnt.sv
// Saturating count of CPU-enabled cycles; clr wins over inc.
module run_ctrl_cnt
   import run_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// CPU run sequencer: reset hold, run/pause/single-step, halt capture.
// Define RUN_CTRL_WATCHDOG_EN to end runs after MAX_CYCLES enabled cycles.
//
// state | meaning
// IDLE  | CPU held in reset, waiting for start
// CRST  | clearing run status, CPU reset held RST_CYCLES cycles
// RUN   | CPU enabled free-running
// PAUSE | CPU stopped, awaiting start (resume) or step
// STEP  | CPU enabled for a single cycle
// DONE  | run ended by halt or watchdog, status held
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int unsigned MAX_CYCLES = 500000,
   parameter int unsigned RST_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        step,
   input  logic        is_halt,
   input  logic [15:0] ret_val,
   output logic        cpu_en,
   output logic        cpu_rst,
   output logic        done,
   output logic        timeout,
   output logic [7:0]  result,
   output logic [31:0] cycles
);

   localparam logic [31:0] RST_LOAD  = 32'(RST_CYCLES - 1);
   localparam logic [31:0] WDOG_LAST = 32'(MAX_CYCLES - 1);

   state_t      state, state_nxt;
   logic [31:0] rst_cnt;
   logic        wdog_hit;
   logic        unused_ret_hi;

   assign unused_ret_hi = ^ret_val[15:8];

`ifdef RUN_CTRL_WATCHDOG_EN
   logic timeout_q;

   // Compare uses the pre-increment count, so DONE is reached with cycles == MAX_CYCLES.
   assign wdog_hit = (cycles == WDOG_LAST);
   assign timeout  = timeout_q;

   always_ff @(posedge clk) begin
      if (rst || (state_nxt == CRST)) begin
         timeout_q <= 1'b0;
      end else if (cpu_on(state) && !is_halt && wdog_hit) begin
         timeout_q <= 1'b1;
      end
   end
`else
   logic unused_wdog;

   assign unused_wdog = ^WDOG_LAST;
   assign wdog_hit    = 1'b0;
   assign timeout     = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = CRST;
         CRST:  if (rst_cnt == '0) state_nxt = RUN;
         RUN, STEP: begin
            if (is_halt || wdog_hit)  state_nxt = DONE;
            else if (state == STEP)   state_nxt = PAUSE;
            else if (stop)            state_nxt = PAUSE;
         end
         PAUSE: begin
            if (start)      state_nxt = RUN;
            else if (step)  state_nxt = STEP;
         end
         DONE:  if (start) state_nxt = CRST;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cpu_en  <= 1'b0;
         cpu_rst <= 1'b1;
         done    <= 1'b0;
         result  <= '0;
         rst_cnt <= RST_LOAD;
      end else begin
         state   <= state_nxt;
         cpu_en  <= cpu_on(state_nxt);
         cpu_rst <= (state_nxt == IDLE) || (state_nxt == CRST);
         done    <= (state_nxt == DONE);
         if (state != CRST) begin
            rst_cnt <= RST_LOAD;
         end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - 32'd1;
         end
         if (state_nxt == CRST) begin
            result <= '0;
         end else if (cpu_on(state) && is_halt) begin
            result <= ret_val[7:0];
         end
      end
   end

   run_ctrl_cnt u_cnt (
      .clk   (clk),
      .clr   (rst || (state_nxt == CRST)),
      .inc   (cpu_en),
      .count (cycles)
   );

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios plus random pulses vs a behavioural model.
module tb_run_ctrl;

   localparam int unsigned MAXC  = 120;
   localparam int unsigned RST_C = 3;

   logic        clk = 1'b0;
   logic        rst, start, stop, step, is_halt;
   logic [15:0] ret_val;
   logic        cpu_en, cpu_rst, done, timeout;
   logic [7:0]  result;
   logic [31:0] cycles;

   int total = 0;
   int bad   = 0;

   run_ctrl #(.MAX_CYCLES(MAXC), .RST_CYCLES(RST_C)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
      .is_halt(is_halt), .ret_val(ret_val), .cpu_en(cpu_en), .cpu_rst(cpu_rst),
      .done(done), .timeout(timeout), .result(result), .cycles(cycles)
   );

   always #5 clk = ~clk;

   // Behavioural model: phase of the run plus run bookkeeping.
   typedef enum {M_OFF, M_RESET, M_GO, M_HOLD, M_ONE, M_END} mphase_t;
   mphase_t     mp = M_OFF;
   int unsigned m_cyc = 0;
   int          m_rleft = 0;
   logic [7:0]  m_res = '0;
   logic        m_to = 1'b0;

`ifdef RUN_CTRL_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   task automatic model_edge(input logic i_rst, i_start, i_stop, i_step, i_halt,
                             input logic [15:0] i_ret);
      int unsigned seen;
      bit running;
      running = (mp == M_GO) || (mp == M_ONE);
      seen = m_cyc;
      if (i_rst) begin
         mp = M_OFF; m_cyc = 0; m_res = '0; m_to = 1'b0;
         return;
      end
      if (running && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (running) begin
         if (i_halt) begin
            mp = M_END; m_res = i_ret[7:0]; m_to = 1'b0;
         end else if (WD && seen + 1 == MAXC) begin
            mp = M_END; m_to = 1'b1;
         end else if (mp == M_ONE || i_stop) begin
            mp = M_HOLD;
         end
      end else if (mp == M_RESET) begin
         m_rleft = m_rleft - 1;
         if (m_rleft == 0) mp = M_GO;
      end else if (mp == M_HOLD) begin
         if (i_start)     mp = M_GO;
         else if (i_step) mp = M_ONE;
      end else if ((mp == M_OFF || mp == M_END) && i_start) begin
         mp = M_RESET; m_rleft = RST_C; m_cyc = 0; m_res = '0; m_to = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic i_rst, i_start, i_stop, i_step, i_halt,
                      input logic [15:0] i_ret);
      rst = i_rst; start = i_start; stop = i_stop; step = i_step;
      is_halt = i_halt; ret_val = i_ret;
      @(posedge clk);
      model_edge(i_rst, i_start, i_stop, i_step, i_halt, i_ret);
      #1;
      chk("cpu_en",  {31'd0, cpu_en},  {31'd0, (mp == M_GO) || (mp == M_ONE)});
      chk("cpu_rst", {31'd0, cpu_rst}, {31'd0, (mp == M_OFF) || (mp == M_RESET)});
      chk("done",    {31'd0, done},    {31'd0, mp == M_END});
      chk("timeout", {31'd0, timeout}, {31'd0, m_to});
      chk("result",  {24'd0, result},  {24'd0, m_res});
      chk("cycles",  cycles,           m_cyc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 16'h0);
   endtask

   task automatic run_to(input int unsigned target);
      for (int g = 0; g < 400 && m_cyc != target; g++) cyc(0, 0, 0, 0, 0, 16'h0);
      chk("run_to", cycles, target);
   endtask

   initial begin
      int en_cnt;
      int rst_cnt;
      cyc(1, 0, 0, 0, 0, 16'h0);
      cyc(1, 1, 1, 1, 1, 16'hFFFF);
      chk("reset_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("reset_cycles", cycles, 32'd0);
      cyc(0, 0, 1, 0, 0, 16'h0);
      cyc(0, 0, 0, 1, 0, 16'h0);
      chk("idle_ignores", {31'd0, cpu_rst}, 32'd1);

      // halt after 50 enabled cycles
      cyc(0, 1, 0, 0, 0, 16'h0);
      run_to(50);
      cyc(0, 0, 0, 0, 1, 16'h1234);
      chk("halt_done", {31'd0, done}, 32'd1);
      chk("halt_timeout", {31'd0, timeout}, 32'd0);
      chk("halt_result", {24'd0, result}, 32'h34);
      chk("halt_cycles", cycles, 32'd51);
      chk("halt_en", {31'd0, cpu_en}, 32'd0);
      cyc(0, 0, 1, 0, 0, 16'h0);
      cyc(0, 0, 0, 1, 1, 16'h00AA);
      chk("done_ignores", {24'd0, result}, 32'h34);

      // rerun, pause at 10, three steps, resume, halt together with stop
      cyc(0, 1, 0, 0, 0, 16'h0);
      chk("rerun_rst", {31'd0, cpu_rst}, 32'd1);
      chk("rerun_result", {24'd0, result}, 32'd0);
      chk("rerun_done", {31'd0, done}, 32'd0);
      run_to(9);
      cyc(0, 0, 1, 0, 0, 16'h0);
      chk("pause_cycles", cycles, 32'd10);
      en_cnt = 0;
      idle(2);
      for (int s = 0; s < 3; s++) begin
         cyc(0, 0, 0, 1, 0, 16'h0);
         en_cnt += int'(cpu_en);
         cyc(0, 0, 1, 0, 0, 16'h0);
         en_cnt += int'(cpu_en);
         cyc(0, 0, 0, 0, 0, 16'h0);
         en_cnt += int'(cpu_en);
      end
      chk("step_cycles", cycles, 32'd13);
      chk("step_en_count", en_cnt, 32'd3);
      cyc(0, 1, 0, 1, 0, 16'h0);
      chk("resume_en", {31'd0, cpu_en}, 32'd1);
      idle(4);
      cyc(0, 0, 1, 0, 1, 16'h5A77);
      chk("halt_stop_done", {31'd0, done}, 32'd1);
      chk("halt_stop_to", {31'd0, timeout}, 32'd0);

      // rerun: count reset-hold cycles, then reset mid-run at cycle 100
      cyc(0, 1, 0, 0, 0, 16'h0);
      rst_cnt = int'(cpu_rst);
      for (int g = 0; g < 20 && !cpu_en; g++) begin
         cyc(0, 0, 0, 0, 0, 16'h0);
         rst_cnt += int'(cpu_rst);
      end
      chk("crst_len", rst_cnt, RST_C);
      run_to(100);
      cyc(1, 0, 0, 0, 0, 16'h0);
      chk("midrun_rst", {31'd0, cpu_rst}, 32'd1);
      chk("midrun_cycles", cycles, 32'd0);

      // watchdog run
      cyc(0, 1, 0, 0, 0, 16'h0);
      for (int g = 0; g < 400 && m_cyc != 125 && mp != M_END; g++) cyc(0, 0, 0, 0, 0, 16'h0);
      idle(3);
`ifdef RUN_CTRL_WATCHDOG_EN
      chk("wd_done", {31'd0, done}, 32'd1);
      chk("wd_timeout", {31'd0, timeout}, 32'd1);
      chk("wd_cycles", cycles, MAXC);
`else
      chk("nowd_en", {31'd0, cpu_en}, 32'd1);
      chk("nowd_cycles", cycles, 32'd128);
      cyc(0, 0, 0, 0, 1, 16'h0001);
`endif
      // halt on the watchdog's last cycle wins
      cyc(0, 1, 0, 0, 0, 16'h0);
      run_to(MAXC - 1);
      cyc(0, 0, 1, 0, 1, 16'h00C3);
      chk("edge_halt_to", {31'd0, timeout}, 32'd0);
      chk("edge_halt_cycles", cycles, MAXC);

      // single steps running into the watchdog
      cyc(0, 1, 0, 0, 0, 16'h0);
      run_to(MAXC - 3);
      cyc(0, 0, 1, 0, 0, 16'h0);
      cyc(0, 0, 0, 1, 0, 16'h0);
      idle(1);
      cyc(0, 0, 0, 1, 0, 16'h0);
      idle(1);
      chk("step_wd_cycles", cycles, MAXC);
      chk("step_wd_done", {31'd0, done}, {31'd0, WD});
      chk("step_wd_to", {31'd0, timeout}, {31'd0, WD});

      // random pulses against the model
      cyc(1, 0, 0, 0, 0, 16'h0);
      for (int i = 0; i < 1500; i++) begin
         cyc(($urandom % 150) == 0, ($urandom % 8) == 0, ($urandom % 10) == 0,
             ($urandom % 5) == 0, ($urandom % 40) == 0, 16'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter MAX_CYCLES, default 500000: watchdog limit in CPU-enabled cycles.
REQ-002 Parameter RST_CYCLES, default 4: CPU reset hold length in cycles, minimum 1.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  pulse; launches a run, resumes from PAUSE, or reruns from DONE.
REQ-006 stop  input  1  pulse; pauses a running CPU.
REQ-007 step  input  1  pulse; in PAUSE, enables the CPU for exactly one cycle.
REQ-008 is_halt  input  1  CPU halt indication; valid only while cpu_en=1.
REQ-009 ret_val  input  16  CPU return register.
REQ-010 cpu_en  output  1  CPU clock enable.
REQ-011 cpu_rst  output  1  CPU reset, active-high.
REQ-012 done  output  1  high while in DONE.
REQ-013 timeout  output  1  in DONE, 1 = ended by watchdog, 0 = ended by halt.
REQ-014 result  output  8  ret_val[7:0] captured at halt.
REQ-015 cycles  output  32  count of cycles with cpu_en=1 in the current run.

Function
REQ-016 The FSM SHALL have states IDLE, CRST, RUN, PAUSE, STEP and DONE; all outputs are registered.
REQ-017 IDLE SHALL hold cpu_rst=1 and cpu_en=0; start moves it to CRST.
REQ-018 CRST SHALL clear cycles, timeout and result, hold cpu_rst=1 for exactly RST_CYCLES cycles, then enter RUN.
REQ-019 RUN and STEP SHALL drive cpu_rst=0 and cpu_en=1; PAUSE and DONE SHALL drive cpu_en=0 and cpu_rst=0.
REQ-020 cycles SHALL increment by 1 in each cycle where cpu_en=1 and saturate at 32'hFFFF_FFFF.
REQ-021 In RUN, is_halt=1 SHALL capture result=ret_val[7:0], set timeout=0 and enter DONE; cpu_en is 0 on the following cycle.
REQ-022 In RUN, reaching cycles==MAX_CYCLES-1 without is_halt SHALL set timeout=1 and enter DONE.
REQ-023 In RUN, stop without is_halt or watchdog expiry SHALL enter PAUSE.
REQ-024 Priority in RUN and STEP SHALL be: is_halt, then watchdog, then stop.
REQ-025 In PAUSE, start SHALL enter RUN; step SHALL enter STEP; if both are asserted, start wins.
REQ-026 STEP SHALL last one cycle: on is_halt it enters DONE as in REQ-021, on watchdog expiry DONE with timeout=1, otherwise PAUSE.
REQ-027 In DONE, start SHALL enter CRST for a fresh run; stop and step SHALL be ignored.
REQ-028 start, stop and step SHALL be ignored in states not listed for them.
REQ-029 done and timeout SHALL be valid from the first DONE cycle; result and cycles SHALL hold steady in DONE.

Reset
REQ-030 rst SHALL force IDLE, cpu_rst=1, cpu_en=0, done=0, timeout=0, result=0 and cycles=0 on the next edge, from any state including mid-CRST and mid-RUN.
REQ-031 rst SHALL take priority over every other input.

Configuration
REQ-032 With RUN_CTRL_WATCHDOG_EN defined, REQ-022 and the watchdog terms of REQ-026 apply.
REQ-033 Without RUN_CTRL_WATCHDOG_EN, the watchdog logic SHALL be absent, timeout SHALL be tied 0, and runs end only on is_halt or rst.

Structure
REQ-034 The state enum and the state widths SHALL live in shared package run_ctrl_pkg.
REQ-035 The saturating cycle counter SHALL be sub-module run_ctrl_cnt, with inputs clr and inc and output count[31:0].

Verification
REQ-036 Reset mid-RUN: assert rst at cycle 100 of a run -> next cycle IDLE, cpu_rst=1, cycles=0.
REQ-037 Halt run: start, then is_halt=1 with ret_val=16'h1234 after 50 enabled cycles -> done=1, timeout=0, result=8'h34, cycles=51, cpu_en=0.
REQ-038 Watchdog run: MAX_CYCLES=20, no halt -> done=1, timeout=1, cycles=20; without RUN_CTRL_WATCHDOG_EN the CPU stays enabled past 20 cycles.
REQ-039 Pause and step: stop at cycles=10, then three step pulses -> cycles=13 with cpu_en high for exactly three single cycles; start then resumes RUN.
REQ-040 Simultaneous events: is_halt and stop in the same RUN cycle -> DONE, timeout=0; with MAX_CYCLES=5, is_halt on the 5th cycle -> timeout=0.
REQ-041 Rerun: start in DONE -> RST_CYCLES cycles with cpu_rst=1, result=0, cycles=0, done=0, then RUN.
